// File: rtl/hash_search_ctrl.sv
// Nonce search controller for a 1-cycle-latency hash core. It issues one nonce per cycle and stops at the first hash under target.
// Optional attempt counter: define ATTEMPT_CNT_EN. When it is undefined, attempts is tied to zero.
module hash_search_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [95:0] bloque_bytes,
    input  logic [7:0]  target,
    input  logic [31:0] nonce_first,
    input  logic [31:0] nonce_last,
    output logic [95:0] core_bloque,
    output logic [31:0] core_nonce,
    input  logic [23:0] core_hash,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [23:0] hash,
    output logic [31:0] nonce_found,
    output logic [31:0] attempts
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  target_reg;
    logic [31:0] last_reg;
    logic        issue_valid_reg;
    logic [31:0] tag_nonce_reg;
    logic        tag_valid_reg;
    logic        accept;
    logic        match;
    logic        range_end;

    assign accept    = (state_reg == IDLE) && start;
    // The tag pairs each core_hash with the nonce that produced it one cycle earlier.
    assign match     = tag_valid_reg && (core_hash[23:16] < target_reg) && (core_hash[15:8] < target_reg);
    assign range_end = tag_valid_reg && (tag_nonce_reg == last_reg);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SEARCH;
            SEARCH: begin
                if (abort)                  state_next = IDLE;
                else if (match | range_end) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == SEARCH);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_bloque     <= '0;
            core_nonce      <= '0;
            target_reg      <= '0;
            last_reg        <= '0;
            issue_valid_reg <= 1'b0;
            tag_nonce_reg   <= '0;
            tag_valid_reg   <= 1'b0;
            found           <= 1'b0;
            hash            <= '0;
            nonce_found     <= '0;
        end else if (accept) begin
            core_bloque     <= bloque_bytes;
            target_reg      <= target;
            last_reg        <= nonce_last;
            core_nonce      <= nonce_first;
            issue_valid_reg <= 1'b1;
            tag_nonce_reg   <= '0;
            tag_valid_reg   <= 1'b0;
            found           <= 1'b0;
            hash            <= '0;
            nonce_found     <= '0;
        end else if (state_reg == SEARCH) begin
            if (abort) begin
                found           <= 1'b0;
                tag_valid_reg   <= 1'b0;
                issue_valid_reg <= 1'b0;
            end else if (match) begin
                hash            <= core_hash;
                nonce_found     <= tag_nonce_reg;
                found           <= 1'b1;
                tag_valid_reg   <= 1'b0;
                issue_valid_reg <= 1'b0;
            end else begin
                tag_nonce_reg <= core_nonce;
                tag_valid_reg <= issue_valid_reg;
                // Once nonce_last has gone out, core_nonce parks and later issues are marked invalid.
                if (issue_valid_reg && (core_nonce != last_reg))
                    core_nonce <= core_nonce + 32'd1;
                else
                    issue_valid_reg <= 1'b0;
            end
        end
    end

`ifdef ATTEMPT_CNT_EN
    logic [31:0] attempts_reg;

    always_ff @(posedge clk) begin
        if (reset)
            attempts_reg <= '0;
        else if (accept)
            attempts_reg <= '0;
        else if ((state_reg == SEARCH) && !abort && tag_valid_reg && (attempts_reg != 32'hFFFF_FFFF))
            attempts_reg <= attempts_reg + 32'd1;
    end

    assign attempts = attempts_reg;
`else
    assign attempts = 32'd0;
`endif

endmodule
